// File: rtl/riscv_dift_tag_prop_if.sv
// Handshake bundle between the EX-side issue logic and the DIFT tag-propagation stage.
// Signal suffixes are written from the stage's point of view.
interface riscv_dift_tag_prop_if #(
    parameter int N_CLASSES = 8,
    parameter int TAG_W     = 1
);
    localparam int CLS_W = $clog2(N_CLASSES);

    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [CLS_W-1:0] in_class_i;
    logic [TAG_W-1:0] in_tag_a_i;
    logic [TAG_W-1:0] in_tag_b_i;
    logic [TAG_W-1:0] in_tag_old_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [TAG_W-1:0] out_tag_o;
    logic             out_viol_o;

    modport slave (
        input  flush_i, in_valid_i, in_class_i, in_tag_a_i, in_tag_b_i, in_tag_old_i, out_ready_i,
        output in_ready_o, out_valid_o, out_tag_o, out_viol_o
    );

    modport master (
        output flush_i, in_valid_i, in_class_i, in_tag_a_i, in_tag_b_i, in_tag_old_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_tag_o, out_viol_o
    );
endinterface

// File: rtl/riscv_dift_tag_prop.sv
// DIFT tag-propagation stage beside EX: per-class programmable mode, one register stage, deferred policy commit.
// Optional saturating violation counter is built only when DIFT_VIOLATION_CNT_EN is defined.
module riscv_dift_tag_prop #(
    parameter int N_CLASSES = 8,
    parameter int TAG_W     = 1,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we_i,
    input  logic [3*N_CLASSES-1:0] cfg_wdata_i,
    output logic                   cfg_busy_o,
    output logic [2*N_CLASSES-1:0] mode_o,
    output logic [N_CLASSES-1:0]   chk_en_o,
    riscv_dift_tag_prop_if.slave   bus,
    output logic [CNT_W-1:0]       viol_cnt_o,
    input  logic                   cnt_clr_i
);
    localparam int CLS_W = $clog2(N_CLASSES);

    typedef enum logic {IDLE, DRAIN} state_e;
    typedef enum logic [1:0] {
        MODE_OLD   = 2'b00,
        MODE_AND   = 2'b01,
        MODE_OR    = 2'b10,
        MODE_CLEAR = 2'b11
    } tagMode_e;

    state_e                 state_q, state_d;
    logic [3*N_CLASSES-1:0] pendCfg_q;
    logic [2*N_CLASSES-1:0] mode_q;
    logic [N_CLASSES-1:0]   chkEn_q;
    logic                   outValid_q;
    logic [TAG_W-1:0]       outTag_q;
    logic                   outViol_q;

    logic                   inReady;
    logic                   accept;
    logic                   commit;
    tagMode_e               selMode;
    logic                   selChk;
    logic [TAG_W-1:0]       resTag;
    logic                   resViol;

    assign inReady = (state_q == IDLE) & (~outValid_q | bus.out_ready_i);
    assign accept  = bus.in_valid_i & inReady;

    // Out-of-range class indices fall through to CLEAR with checking disabled.
    always_comb begin
        selMode = MODE_CLEAR;
        selChk  = 1'b0;
        for (int k = 0; k < N_CLASSES; k++) begin
            if (bus.in_class_i == CLS_W'(k)) begin
                selMode = tagMode_e'(mode_q[2*k +: 2]);
                selChk  = chkEn_q[k];
            end
        end
        case (selMode)
            MODE_OLD: resTag = bus.in_tag_old_i;
            MODE_AND: resTag = bus.in_tag_a_i & bus.in_tag_b_i;
            MODE_OR:  resTag = bus.in_tag_a_i | bus.in_tag_b_i;
            default:  resTag = '0;
        endcase
        resViol = selChk & (|resTag);
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_we_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!cfg_we_i && (!outValid_q || bus.out_ready_i || bus.flush_i)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pendCfg_q <= '0;
            mode_q    <= '0;
            chkEn_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_we_i) pendCfg_q <= cfg_wdata_i;
            if (commit) begin
                mode_q  <= pendCfg_q[2*N_CLASSES-1:0];
                chkEn_q <= pendCfg_q[3*N_CLASSES-1:2*N_CLASSES];
            end
        end
    end

    // A flush wins over a same-cycle accept, so the killed item never appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outTag_q   <= '0;
            outViol_q  <= 1'b0;
        end else if (bus.flush_i) begin
            outValid_q <= 1'b0;
        end else if (accept) begin
            outValid_q <= 1'b1;
            outTag_q   <= resTag;
            outViol_q  <= resViol;
        end else if (bus.out_ready_i) begin
            outValid_q <= 1'b0;
        end
    end

`ifdef DIFT_VIOLATION_CNT_EN
    logic [CNT_W-1:0] violCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            violCnt_q <= '0;
        end else if (cnt_clr_i) begin
            violCnt_q <= '0;
        end else if (outValid_q && bus.out_ready_i && outViol_q && (violCnt_q != '1)) begin
            violCnt_q <= violCnt_q + CNT_W'(1);
        end
    end

    assign viol_cnt_o = violCnt_q;
`else
    logic unusedCntClr;
    assign unusedCntClr = cnt_clr_i;
    assign viol_cnt_o   = '0;
`endif

    assign cfg_busy_o      = (state_q == DRAIN);
    assign mode_o          = mode_q;
    assign chk_en_o        = chkEn_q;
    assign bus.in_ready_o  = inReady;
    assign bus.out_valid_o = outValid_q;
    assign bus.out_tag_o   = outTag_q;
    assign bus.out_viol_o  = outViol_q;
endmodule
